// File: rtl/ttt_pkg.sv
// Shared types and helpers for the tic-tac-toe board controller.
// Cell codes double as sprite codes on the video path.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P_A   = 2'b01,
    P_B   = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    DONE
  } state_t;

  function automatic cell_t other_player(cell_t c);
    return (c == P_A) ? P_B : P_A;
  endfunction

endpackage

// File: rtl/ttt_line_scan.sv
// Combinational single-line matcher: rows, then columns, then both diagonals.
// Code 11 can never equal last_code (always 01/10), so it reads as empty.
module ttt_line_scan
  import ttt_pkg::*;
#(
  parameter  int N      = 3,
  localparam int LINE_W = $clog2(2*N+2)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [LINE_W-1:0] line_idx,
  input  logic [1:0]        last_code,
  output logic              match
);

  localparam int LINES = 2*N + 2;

  logic [(2**LINE_W)-1:0] line_hit;
  logic [N-1:0]           eq [LINES];

  for (genvar ln = 0; ln < LINES; ln++) begin : g_line
    for (genvar k = 0; k < N; k++) begin : g_cell
      // Cell visited by step k of line ln, resolved at elaboration time.
      localparam int IDX = (ln < N)   ? ln*N + k :
                           (ln < 2*N) ? k*N + (ln - N) :
                           (ln == 2*N) ? k*N + k :
                                         k*N + (N - 1 - k);
      assign eq[ln][k] = (board[2*IDX +: 2] == last_code);
    end
    assign line_hit[ln] = &eq[ln];
  end

  if ((2**LINE_W) > LINES) begin : g_pad
    assign line_hit[(2**LINE_W)-1:LINES] = '0;
  end

  assign match = line_hit[line_idx];

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game engine: cursor, placement, turn tracking and a
// one-line-per-cycle win/draw scan feeding the video controller.
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter  int         N          = 3,
  parameter  logic [1:0] START_CODE = 2'b01,
  localparam int         SEL_W      = $clog2(N*N)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_place,
  input  logic               new_game,
  output logic [2*N*N-1:0]   board,
  output logic [SEL_W-1:0]   selected,
  output logic [1:0]         turn,
  output logic               busy,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               draw,
  output logic               invalid_move
);

  localparam int CELLS  = N*N;
  localparam int RC_W   = $clog2(N);
  localparam int LINE_W = $clog2(2*N+2);
  localparam int MC_W   = $clog2(N*N+1);

  state_t            state_q, state_n;
  cell_t             cells_q [CELLS];
  cell_t             cells_n [CELLS];
  logic [RC_W-1:0]   row_q, row_n, col_q, col_n;
  logic [SEL_W-1:0]  sel_q, sel_n;
  cell_t             turn_q, turn_n, last_q, last_n;
  logic [MC_W-1:0]   cnt_q, cnt_n;
  logic [LINE_W-1:0] line_q, line_n;
  logic              busy_q, busy_n, over_q, over_n, draw_q, draw_n, inv_q, inv_n;
  logic [1:0]        win_q, win_n;
  logic              match;

  for (genvar i = 0; i < CELLS; i++) begin : g_pack
    assign board[2*i +: 2] = cells_q[i];
  end

  ttt_line_scan #(.N(N)) u_scan (
    .board     (board),
    .line_idx  (line_q),
    .last_code (last_q),
    .match     (match)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path can infer a latch.
    state_n = state_q;
    cells_n = cells_q;
    row_n   = row_q;
    col_n   = col_q;
    turn_n  = turn_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    line_n  = line_q;
    busy_n  = busy_q;
    over_n  = over_q;
    draw_n  = draw_q;
    win_n   = win_q;
    inv_n   = 1'b0;

    // new_game is honoured everywhere except mid-scan; the cursor survives it.
    if (new_game && state_q != CHECK) begin
      for (int i = 0; i < CELLS; i++) cells_n[i] = EMPTY;
      state_n = PLAY;
      turn_n  = cell_t'(START_CODE);
      cnt_n   = '0;
      line_n  = '0;
      busy_n  = 1'b0;
      over_n  = 1'b0;
      draw_n  = 1'b0;
      win_n   = 2'b00;
    end else begin
      case (state_q)
        PLAY: begin
          if (btn_place) begin
            if (cells_q[sel_q] == EMPTY) begin
              cells_n[sel_q] = turn_q;
              cnt_n   = cnt_q + 1'b1;
              last_n  = turn_q;
              line_n  = '0;
              busy_n  = 1'b1;
              state_n = CHECK;
            end else begin
              inv_n = 1'b1;
            end
          end else if (btn_up) begin
            row_n = (row_q == '0) ? RC_W'(N-1) : row_q - 1'b1;
          end else if (btn_down) begin
            row_n = (row_q == RC_W'(N-1)) ? '0 : row_q + 1'b1;
          end else if (btn_left) begin
            col_n = (col_q == '0) ? RC_W'(N-1) : col_q - 1'b1;
          end else if (btn_right) begin
            col_n = (col_q == RC_W'(N-1)) ? '0 : col_q + 1'b1;
          end
        end
        CHECK: begin
          if (match) begin
            win_n   = last_q;
            over_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = DONE;
          end else if (line_q == LINE_W'(2*N+1)) begin
            busy_n = 1'b0;
            if (cnt_q == MC_W'(CELLS)) begin
              draw_n  = 1'b1;
              over_n  = 1'b1;
              state_n = DONE;
            end else begin
              turn_n  = other_player(turn_q);
              state_n = PLAY;
            end
          end else begin
            line_n = line_q + 1'b1;
          end
        end
        DONE:    ;
        default: state_n = PLAY;
      endcase
    end

    sel_n = SEL_W'(int'(row_n) * N + int'(col_n));
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= PLAY;
      // NOTE: the board is a flop array rather than a RAM, so clearing it in reset is legitimate.
      for (int i = 0; i < CELLS; i++) cells_q[i] <= EMPTY;
      row_q  <= '0;
      col_q  <= '0;
      sel_q  <= '0;
      turn_q <= cell_t'(START_CODE);
      last_q <= cell_t'(START_CODE);
      cnt_q  <= '0;
      line_q <= '0;
      busy_q <= 1'b0;
      over_q <= 1'b0;
      draw_q <= 1'b0;
      win_q  <= 2'b00;
      inv_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cells_q <= cells_n;
      row_q   <= row_n;
      col_q   <= col_n;
      sel_q   <= sel_n;
      turn_q  <= turn_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
      line_q  <= line_n;
      busy_q  <= busy_n;
      over_q  <= over_n;
      draw_q  <= draw_n;
      win_q   <= win_n;
      inv_q   <= inv_n;
    end
  end

  assign selected     = sel_q;
  assign turn         = turn_q;
  assign busy         = busy_q;
  assign game_over    = over_q;
  assign winner       = win_q;
  assign draw         = draw_q;
  assign invalid_move = inv_q;

endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Parametrised game-logic engine for an N×N tic-tac-toe board. It replaces the constant block/selected assignments currently feeding video_controller.
- Holds board state, cursor position, turn, move count and win/draw status.
- Accepts single-cycle button pulses and runs a sequential line-scan win checker after each legal placement.
- Output bus packs per-cell sprite codes directly into the video path.

Parameters:
- N, 3, board side length (legal 3..8).
- START_CODE, 2'b01, sprite code of the player who moves first; the other player is 2'b10.
- SEL_W, $clog2(N*N), localparam, cursor index width.

Ports:
- CLOCK_50  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- btn_up  in  1  cursor up, one-cycle pulse (debounced upstream).
- btn_down  in  1  cursor down pulse.
- btn_left  in  1  cursor left pulse.
- btn_right  in  1  cursor right pulse.
- btn_place  in  1  place mark at cursor, pulse.
- new_game  in  1  clear board, pulse.
- board  out  2*N*N  cell (r,c) occupies bits [2*(r*N+c)+1 : 2*(r*N+c)].
- selected  out  SEL_W  cursor index, row*N+col.
- turn  out  2  sprite code of the player to move.
- busy  out  1  win check in progress.
- game_over  out  1  win or draw reached.
- winner  out  2  00 none, 01 or 10 = winning code.
- draw  out  1  board full, no winner.
- invalid_move  out  1  one-cycle pulse on a rejected placement.

Behaviour:
- Cell codes: 00 empty, 01 player A, 10 player B. Code 11 is never written and is treated as empty by the checker.
- Reset (synchronous, active-high): board=0, selected=0, turn=START_CODE, move_cnt=0, busy=0, game_over=0, winner=00, draw=0, invalid_move=0, state=PLAY. Reset mid-CHECK aborts the scan.
- States: PLAY, CHECK, DONE.
- PLAY, priority new_game > btn_place > up > down > left > right; exactly one action per cycle, all others that cycle are dropped.
  - Cursor moves wrap within the row or column: up from row 0 goes to row N-1; right from col N-1 goes to col 0. selected updates the next cycle.
  - btn_place on an empty cell: write turn to the cell, move_cnt+1, latch last_code=turn, line_idx=0, busy=1, go to CHECK.
  - btn_place on an occupied cell: no state change; invalid_move=1 for exactly one cycle.
- CHECK evaluates one line per cycle, in line_idx order:
  - 0..N-1 rows.
  - N..2N-1 columns.
  - 2N main diagonal.
  - 2N+1 anti-diagonal.
- Line match: all N cells equal last_code.
  - On a match: winner=last_code, game_over=1, busy=0, go to DONE (early exit).
  - After line 2N+1 with no match:
    - If move_cnt==N*N: draw=1, game_over=1, go to DONE.
    - Otherwise: toggle turn (01↔10), busy=0, go to PLAY.
  - Worst-case latency is 2N+2 cycles after the place pulse. Buttons are ignored during CHECK; new_game during CHECK is also ignored.
- DONE: only new_game acts; board, winner and draw hold. Cursor moves are ignored.
- new_game (in PLAY or DONE) clears the same state as reset, except selected, which holds. It takes effect the next cycle.
- move_cnt is $clog2(N*N+1) bits wide and cannot overflow, because placement is blocked once the board is full.
- All outputs are registered.

Decomposition:
- Package ttt_pkg:
  - cell_t enum: EMPTY=2'b00, P_A=2'b01, P_B=2'b10.
  - state_t enum: PLAY, CHECK, DONE.
  - Function other_player(cell_t).
- Sub-module ttt_line_scan: given board, line_idx and last_code, combinationally produces match. It holds the row/col/diagonal index arithmetic for parameter N.
- The top-level controller instantiates ttt_line_scan and holds the FSM, cursor and counters.

Test Plan:
- Reset, then 4×btn_right with N=3 -> selected sequence 1,2,0,1. Then btn_up -> selected=7 (wrap to row 2).
- Place A at 0, B at 4, A at 1, B at 5, A at 2 -> after the last place:
  - busy for at most 1 cycle (line 0 matches first);
  - winner=01, game_over=1;
  - board[5:0]=6'b010101.
- Place on the occupied cell 4 -> invalid_move high exactly 1 cycle; turn and board unchanged.
- Anti-diagonal win (cells 2,4,6 = B) -> CHECK lasts 2N+2=8 cycles, winner=10. Buttons pulsed during CHECK have no effect.
- Nine-move draw sequence A:0,B:1,A:2,B:4,A:3,B:5,A:7,B:6,A:8 -> draw=1, winner=00, game_over=1. Then new_game -> board=0, turn=01, selected retained.
- N=4 build: wrap at index 15 -> 12 on btn_right. Full-column win on col 3 (cells 3,7,11,15) -> winner reported.
